// File: rtl/event_logger_pkg.sv
// rtl/event_logger_pkg.sv - default sizes and shared types for the event logger
package event_logger_pkg;

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_TS_W   = 16;
  localparam int DEFAULT_DROP_W = 8;

  typedef logic [DEFAULT_TS_W-1:0] ts_t;

endpackage

// File: rtl/event_logger_fifo.sv
// rtl/event_logger_fifo.sv - synchronous FIFO holding captured timestamps
module event_logger_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [W-1:0]             rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop & ~empty & ~clear;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & ~clear & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      level <= level + LVL_ONE;
      else if (do_pop && !do_push) level <= level - LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/event_logger.sv
// rtl/event_logger.sv - timestamps enabled events into a FIFO and counts drops
module event_logger import event_logger_pkg::*; #(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int TS_W   = DEFAULT_TS_W,
  parameter int DROP_W = DEFAULT_DROP_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    event_occurred,
  input  logic                    clear,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [TS_W-1:0]         rd_timestamp,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [DROP_W-1:0]       dropped
);

  localparam logic [TS_W-1:0]   TS_ONE   = TS_W'(1);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  logic [TS_W-1:0] ts_cnt;
  logic            push_req;
  logic            full;
  logic            empty;
  logic            drop;

  assign push_req = enable & event_occurred;
  assign rd_valid = ~empty;
  // Full implies valid, so rd_ready alone decides whether the head leaves.
  assign drop     = push_req & full & ~rd_ready & ~clear;

  event_logger_fifo #(
    .DEPTH (DEPTH),
    .W     (TS_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (push_req),
    .pop     (rd_ready),
    .wr_data (ts_cnt),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .rd_data (rd_timestamp)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt   <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else if (clear) begin
      ts_cnt   <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else begin
      if (enable) ts_cnt <= ts_cnt + TS_ONE;
      if (drop) begin
        overflow <= 1'b1;
        if (dropped != {DROP_W{1'b1}}) dropped <= dropped + DROP_ONE;
      end
    end
  end

endmodule

// File: tb/tb_event_logger.sv
// tb/tb_event_logger.sv - self-checking bench for event_logger against a queue model
module tb_event_logger;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        event_occurred;
  logic        clear;
  logic        rd_ready;
  logic        rd_valid, rd_valid4;
  logic [15:0] rd_timestamp;
  logic [3:0]  rd_timestamp4;
  logic [3:0]  level, level4;
  logic        overflow, overflow4;
  logic [7:0]  dropped, dropped4;

  int checks = 0;
  int errors = 0;

  int m_ts;
  int q[$];
  bit m_ovf;
  int m_drops;

  always #5 clk = ~clk;

  event_logger u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .event_occurred (event_occurred),
    .clear          (clear),
    .rd_ready       (rd_ready),
    .rd_valid       (rd_valid),
    .rd_timestamp   (rd_timestamp),
    .level          (level),
    .overflow       (overflow),
    .dropped        (dropped)
  );

  event_logger #(.DEPTH(8), .TS_W(4), .DROP_W(8)) u_dut4 (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .event_occurred (event_occurred),
    .clear          (clear),
    .rd_ready       (rd_ready),
    .rd_valid       (rd_valid4),
    .rd_timestamp   (rd_timestamp4),
    .level          (level4),
    .overflow       (overflow4),
    .dropped        (dropped4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ts = 0;
    m_ovf = 1'b0;
    m_drops = 0;
  endtask

  task automatic model_update(input bit en, input bit ev, input bit clr, input bit rdy);
    bit was_full;
    bit popped;
    if (clr) begin
      model_clear();
    end else begin
      was_full = (q.size() == DEPTH);
      popped = (q.size() > 0) && rdy;
      if (popped) void'(q.pop_front());
      if (en && ev) begin
        if (!was_full || popped) q.push_back(m_ts);
        else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
      if (en) m_ts = (m_ts + 1) % 65536;
    end
  endtask

  task automatic check_all(input string tag);
    int head;
    head = (q.size() > 0) ? q[0] : 0;
    chk({tag, ":valid"},    32'(rd_valid),      32'(q.size() > 0));
    chk({tag, ":ts"},       32'(rd_timestamp),  32'(head));
    chk({tag, ":level"},    32'(level),         32'(q.size()));
    chk({tag, ":ovf"},      32'(overflow),      32'(m_ovf));
    chk({tag, ":dropped"},  32'(dropped),       32'(m_drops));
    chk({tag, ":valid4"},   32'(rd_valid4),     32'(q.size() > 0));
    chk({tag, ":ts4"},      32'(rd_timestamp4), 32'(head % 16));
    chk({tag, ":level4"},   32'(level4),        32'(q.size()));
    chk({tag, ":ovf4"},     32'(overflow4),     32'(m_ovf));
    chk({tag, ":dropped4"}, 32'(dropped4),      32'(m_drops));
  endtask

  task automatic step(input bit en, input bit ev, input bit clr, input bit rdy, input string tag);
    enable = en;
    event_occurred = ev;
    clear = clr;
    rd_ready = rdy;
    @(posedge clk);
    model_update(en, ev, clr, rdy);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    enable = 1'b0;
    event_occurred = 1'b0;
    clear = 1'b0;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    enable = 1'b0;
    event_occurred = 1'b0;
    clear = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    do_reset("reset");

    // single event at ts=3 with consumer ready
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, "r035_idle");
    step(1, 1, 0, 1, "r035_push");
    chk("r035_valid", 32'(rd_valid), 1);
    chk("r035_ts", 32'(rd_timestamp), 3);
    step(1, 0, 0, 1, "r035_pop");
    chk("r035_level", 32'(level), 0);

    // fill to full, one drop, simultaneous push/pop at full, then drain
    step(0, 0, 1, 0, "r036_clr");
    step(1, 0, 0, 0, "r036_ts0");
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, "r036_fill");
    step(1, 1, 0, 0, "r036_drop");
    chk("r036_level", 32'(level), 8);
    chk("r036_ovf", 32'(overflow), 1);
    chk("r036_dropped", 32'(dropped), 1);
    chk("r036_head", 32'(rd_timestamp), 1);
    step(1, 1, 0, 1, "r037_pushpop");
    chk("r037_level", 32'(level), 8);
    chk("r037_head", 32'(rd_timestamp), 2);
    chk("r037_dropped", 32'(dropped), 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, "r036_drain");
    chk("r036_empty", 32'(rd_valid), 0);

    // hold stability while rd_ready low, and rd_ready with nothing stored
    step(1, 1, 0, 0, "hold_push");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "hold_wait");
    step(0, 0, 0, 1, "hold_pop");
    step(0, 0, 0, 1, "empty_rdy");

    // disabled events are ignored and the counter holds
    step(0, 0, 1, 0, "r038_clr");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "r038_run");
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, "r038_off");
    chk("r038_level", 32'(level), 0);
    step(1, 1, 0, 0, "r038_on");
    chk("r038_ts", 32'(rd_timestamp), 3);

    // wrap in the 4-bit build
    step(0, 0, 1, 0, "r039_clr");
    for (int i = 0; i < 15; i++) step(1, 0, 0, 0, "r039_run");
    step(1, 1, 0, 0, "r039_ev15");
    step(1, 1, 0, 0, "r039_ev0");
    chk("r039_head4", 32'(rd_timestamp4), 15);
    step(0, 0, 0, 1, "r039_pop");
    chk("r039_next4", 32'(rd_timestamp4), 0);

    // clear beats a same-cycle push with 3 entries stored and overflow set
    step(0, 0, 1, 0, "r040_clr0");
    for (int i = 0; i < 9; i++) step(1, 1, 0, 0, "r040_fill");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, "r040_drain");
    chk("r040_level3", 32'(level), 3);
    step(1, 1, 1, 1, "r040_clear");
    chk("r040_level", 32'(level), 0);
    chk("r040_ovf", 32'(overflow), 0);
    chk("r040_dropped", 32'(dropped), 0);
    step(1, 1, 0, 0, "r040_ts0");
    chk("r040_ts", 32'(rd_timestamp), 0);

    // dropped saturates
    for (int i = 0; i < 270; i++) step(1, 1, 0, 0, "sat");
    chk("sat_dropped", 32'(dropped), 255);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1, "rand");

    // reset mid-burst
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, "burst");
    do_reset("r040_reset");
    chk("r040_rst_valid", 32'(rd_valid), 0);
    step(1, 1, 0, 0, "post_reset");
    chk("post_reset_ts", 32'(rd_timestamp), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/event_logger.md
EVENT_LOGGER -- requirements
Module: event_logger

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; power of two, minimum 2.
REQ-002 Parameter TS_W, default 16: timestamp width in bits.
REQ-003 Parameter DROP_W, default 8: dropped-event counter width in bits.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  logging enable; gates the timestamp counter and event capture.
REQ-007 event_occurred  input  1  event strobe from event_monitor; each high cycle is one event.
REQ-008 clear  input  1  synchronous flush of FIFO, flags and counters.
REQ-009 rd_ready  input  1  consumer accepts the head entry.
REQ-010 rd_valid  output  1  FIFO non-empty; head entry presented.
REQ-011 rd_timestamp  output  TS_W  timestamp of the head entry.
REQ-012 level  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013 overflow  output  1  sticky flag; an event was dropped.
REQ-014 dropped  output  DROP_W  saturating count of dropped events.

Function
REQ-015 The timestamp counter (TS_W bits) SHALL increment by 1 each cycle enable=1, hold when enable=0, and wrap from 2^TS_W-1 to 0.
REQ-016 A push SHALL occur when event_occurred=1 and enable=1; the stored value SHALL be the counter value in that same cycle, before its increment.
REQ-017 Latency: an event pushed into an empty FIFO in cycle N SHALL give rd_valid=1 with that timestamp in cycle N+1.
REQ-018 A pop SHALL occur when rd_valid=1 and rd_ready=1; the next entry, or rd_valid=0, SHALL appear the following cycle.
REQ-019 rd_timestamp SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-020 rd_ready while rd_valid=0 SHALL have no effect.
REQ-021 Entries SHALL be delivered in push order. Pointers wrap modulo DEPTH.
REQ-022 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full. level is unchanged.
REQ-023 Full with no pop: the push SHALL be dropped, overflow SHALL be set, and dropped SHALL increment, saturating at 2^DROP_W-1.
REQ-024 overflow and dropped SHALL clear only on reset or clear.
REQ-025 event_occurred while enable=0 SHALL be ignored; it is neither stored nor counted as dropped.
REQ-026 clear=1 SHALL take priority over same-cycle push and pop: empty the FIFO, set level=0, overflow=0, dropped=0 and the timestamp counter to 0 in the next cycle.
REQ-027 level SHALL always equal pushes minus pops since the last reset or clear, within 0..DEPTH.

Reset
REQ-028 reset_n=0 SHALL immediately force rd_valid=0, rd_timestamp=0, level=0, overflow=0, dropped=0, the timestamp counter to 0, and both pointers to 0.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries; FIFO storage contents need not be reset.
REQ-030 Reset release SHALL be synchronised by the consumer of this block. The block itself SHALL start operating on the first posedge clk after reset_n=1.

Structure
REQ-031 Package event_logger_pkg SHALL hold the DEPTH, TS_W and DROP_W defaults and typedef ts_t (logic [TS_W-1:0]).
REQ-032 One sub-module, event_logger_fifo, SHALL implement the synchronous FIFO: push, pop, full, empty, level and head data.
REQ-033 The top level SHALL contain the timestamp counter, the drop/overflow logic and the clear handling.
REQ-034 The RTL SHALL contain no latches, and only this one clock.

Verification
REQ-035 Reset release, enable=1 at ts=0, event_occurred high in the cycle with ts=3, rd_ready=1 -> rd_valid=1 for one cycle with rd_timestamp=3, then level=0.
REQ-036 rd_ready=0, events at ts=1..8 (8 events), event at ts=9 -> level=8, overflow=1, dropped=1; then drain -> timestamps 1..8 in order.
REQ-037 FIFO full, event_occurred=1 and rd_ready=1 in the same cycle -> level stays 8, the head pops, the new timestamp enters at the tail, dropped unchanged.
REQ-038 enable=0 for 5 cycles with event_occurred=1 -> no push, counter holds, dropped unchanged; re-enable, event -> timestamp is the held value.
REQ-039 Counter preloaded near wrap (TS_W=4 build): events at ts=15 and the next cycle -> entries 15 then 0.
REQ-040 clear=1 with 3 entries stored, overflow=1 and a same-cycle push -> next cycle level=0, rd_valid=0, overflow=0, dropped=0, counter=0; reset_n=0 mid-burst -> all outputs 0 immediately.
